// File: rtl/bk_sub_pipe_if.sv
// Operand/result valid-ready bundle for bk_sub_pipe.
// BK_SUB_FLAGS_EN adds the zero and lt_s result flags.
interface bk_sub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
`ifdef BK_SUB_FLAGS_EN
    logic             zero;
    logic             lt_s;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf, zero, lt_s
    );
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf, zero, lt_s
    );
`else
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );
`endif
endinterface

// File: rtl/bk_sub_pipe.sv
// 3-stage Brent-Kung subtractor d = a - b - bin with valid/ready flow.
// BK_SUB_FLAGS_EN adds registered zero and signed less-than flags.
module bk_sub_pipe #(
    parameter int WIDTH = 16,
    parameter int LOG2W = 4
) (
    input logic         clk,
    input logic         rst,
    bk_sub_pipe_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             c0;
        logic             a_msb;
        logic             b_msb;
    } s1_t;

    // p keeps only the low bits; the top propagate is rebuilt from the signs
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] pg;
        logic [WIDTH-2:0] p;
        logic             c0;
        logic             a_msb;
        logic             b_msb;
    } s2_t;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
`ifdef BK_SUB_FLAGS_EN
        logic             zero;
        logic             lt_s;
`endif
    } s3_t;

    s1_t s1_q, s1_d;
    s2_t s2_q, s2_d;
    s3_t s3_q, s3_d;

    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic s1_adv, s2_adv, s3_adv;
    logic ld1, ld2, ld3;

    logic [WIDTH-1:0] gu, pu;
    logic [WIDTH-1:0] gd, pd;
    logic [WIDTH:0]   c;

    always_comb begin
        s3_adv = ~v3_q | bus.out_ready;
        s2_adv = ~v2_q | s3_adv;
        s1_adv = ~v1_q | s2_adv;
        ld1    = s1_adv & bus.in_valid;
        ld2    = s2_adv & v1_q;
        ld3    = s3_adv & v2_q;
        v1_d   = s1_adv ? bus.in_valid : v1_q;
        v2_d   = s2_adv ? v1_q : v2_q;
        v3_d   = s3_adv ? v2_q : v3_q;
    end

    assign bus.in_ready = s1_adv;

    always_comb begin
        s1_d       = '0;
        s1_d.g     = bus.a & ~bus.b;
        s1_d.p     = bus.a ^ ~bus.b;
        s1_d.c0    = ~bus.bin;
        s1_d.a_msb = bus.a[WIDTH-1];
        s1_d.b_msb = bus.b[WIDTH-1];
    end

    // Up-sweep: node i merges with i-2^l when i+1 is a multiple of 2^(l+1)
    always_comb begin
        gu = s1_q.g;
        pu = s1_q.p;
        for (int l = 0; l < LOG2W; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gu[i] = gu[i] | (pu[i] & gu[i-(1<<l)]);
                    pu[i] = pu[i] & pu[i-(1<<l)];
                end
            end
        end
        s2_d       = '0;
        s2_d.g     = gu;
        s2_d.pg    = pu;
        s2_d.p     = s1_q.p[WIDTH-2:0];
        s2_d.c0    = s1_q.c0;
        s2_d.a_msb = s1_q.a_msb;
        s2_d.b_msb = s1_q.b_msb;
    end

    // Down-sweep fills the remaining prefixes, then carries and sum
    always_comb begin
        gd = s2_q.g;
        pd = s2_q.pg;
        for (int l = LOG2W - 2; l >= 0; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i > (1 << l))) begin
                    gd[i] = gd[i] | (pd[i] & gd[i-(1<<l)]);
                    pd[i] = pd[i] & pd[i-(1<<l)];
                end
            end
        end
        c    = '0;
        c[0] = s2_q.c0;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = gd[i] | (pd[i] & s2_q.c0);
        end
        s3_d                = '0;
        s3_d.d[WIDTH-2:0]   = s2_q.p ^ c[WIDTH-2:0];
        s3_d.d[WIDTH-1]     = s2_q.a_msb ^ ~s2_q.b_msb ^ c[WIDTH-1];
        s3_d.bout           = ~c[WIDTH];
        s3_d.ovf            = c[WIDTH] ^ c[WIDTH-1];
`ifdef BK_SUB_FLAGS_EN
        s3_d.zero           = (s3_d.d == '0);
        s3_d.lt_s           = s3_d.d[WIDTH-1] ^ s3_d.ovf;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (ld1) s1_q <= s1_d;
            if (ld2) s2_q <= s2_d;
            if (ld3) s3_q <= s3_d;
        end
    end

    assign bus.out_valid = v3_q;
    assign bus.d         = s3_q.d;
    assign bus.bout      = s3_q.bout;
    assign bus.ovf       = s3_q.ovf;
`ifdef BK_SUB_FLAGS_EN
    assign bus.zero      = s3_q.zero;
    assign bus.lt_s      = s3_q.lt_s;
`endif

endmodule

// File: tb/tb_bk_sub_pipe.sv
// Directed and randomized checks for bk_sub_pipe.
// Flag checks are compiled in with BK_SUB_FLAGS_EN.
module tb_bk_sub_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bk_sub_pipe_if #(.WIDTH(16)) bus ();

    bk_sub_pipe #(.WIDTH(16), .LOG2W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int npass = 0;

    // Hand-computed vectors; te = {bout, ovf, d}
    logic [15:0] ta [9] = '{16'h9999, 16'h000A, 16'h1212, 16'h1235,
                            16'h8000, 16'hFFFF, 16'h1234, 16'h0000,
                            16'h7FFF};
    logic [15:0] tbv [9] = '{16'h1000, 16'h100F, 16'hABCD, 16'h1004,
                             16'h0001, 16'hFFFF, 16'h1234, 16'h0001,
                             16'hFFFF};
    logic        tbin [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0};
    logic [17:0] te [9] = '{{2'b00, 16'h8998}, {2'b10, 16'hEFFB},
                            {2'b10, 16'h6645}, {2'b00, 16'h0230},
                            {2'b01, 16'h7FFF}, {2'b10, 16'hFFFF},
                            {2'b00, 16'h0000}, {2'b10, 16'hFFFF},
                            {2'b11, 16'h8000}};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outv();
        return {13'd0, bus.out_valid, bus.bout, bus.ovf, bus.d};
    endfunction

    function automatic logic [17:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic bin);
        logic [16:0] r;
        logic        o;
        r = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        o = (a[15] ^ b[15]) & (a[15] ^ r[15]);
        return {r[16], o, r[15:0]};
    endfunction

    function automatic logic model_lt(input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic bin);
        logic [17:0] s;
        s = {{2{a[15]}}, a} - {{2{b[15]}}, b} - {17'd0, bin};
        return s[17];
    endfunction

    task automatic chk_res(input string tag, input logic [17:0] e,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic bin);
        chk(tag, outv(), {13'd0, 1'b1, e});
`ifdef BK_SUB_FLAGS_EN
        chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, e[15:0] == 16'd0});
        chk({tag, "_lts"}, {31'd0, bus.lt_s}, {31'd0, model_lt(a, b, bin)});
`else
        if (a == b && bin == 1'b1) $display("note: %h", a);
`endif
    endtask

    task automatic chk_tab(input string tag, input int e);
        chk_res(tag, te[e], ta[e], tbv[e], tbin[e]);
    endtask

    task automatic drive(input int e);
        bus.in_valid = 1'b1;
        bus.a        = ta[e];
        bus.b        = tbv[e];
        bus.bin      = tbin[e];
    endtask

    // Stream table entries first..first+n-1 with out_ready held high
    task automatic run_stream(input string tag, input int first,
                              input int n);
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) drive(first + j);
            else bus.in_valid = 1'b0;
            #1;
            chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
            step();
            if (j >= 2) chk_tab(tag, first + j - 2);
            else chk({tag, "_empty"}, {31'd0, bus.out_valid}, 32'd0);
        end
        bus.in_valid = 1'b0;
        step();
        chk({tag, "_drain"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    logic [17:0] q[$];
    logic [17:0] ex;
    logic [15:0] qa[$], qb[$];
    logic        qbin[$];
    int          sent, cyc;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_state", outv(), 32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // Single beat latency
        bus.out_ready = 1'b1;
        drive(0);
        step();
        bus.in_valid = 1'b0;
        chk("lat1", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("lat2", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk_tab("lat3", 0);
        step();
        chk("lat_gone", {31'd0, bus.out_valid}, 32'd0);

        run_stream("stream", 1, 3);
        run_stream("bound", 4, 5);

        // Backpressure with entries 4..8
        bus.out_ready = 1'b0;
        drive(4);
        #1;
        chk("bp_rdy0", {31'd0, bus.in_ready}, 32'd1);
        step();
        drive(5);
        #1;
        chk("bp_rdy1", {31'd0, bus.in_ready}, 32'd1);
        step();
        drive(6);
        #1;
        chk("bp_rdy2", {31'd0, bus.in_ready}, 32'd1);
        step();
        drive(7);
        #1;
        chk("bp_full", {31'd0, bus.in_ready}, 32'd0);
        chk_tab("bp_hold0", 4);
        step();
        chk("bp_full2", {31'd0, bus.in_ready}, 32'd0);
        chk_tab("bp_hold1", 4);
        step();
        chk_tab("bp_hold2", 4);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk_tab("bp_out5", 5);
        drive(8);
        step();
        bus.in_valid = 1'b0;
        chk_tab("bp_out6", 6);
        step();
        chk_tab("bp_out7", 7);
        step();
        chk_tab("bp_out8", 8);
        step();
        chk("bp_drain", {31'd0, bus.out_valid}, 32'd0);

        // Reset with two beats in flight
        drive(0);
        step();
        drive(1);
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_v", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_r", {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mid_rst_flush", {31'd0, bus.out_valid}, 32'd0);
        end

        // Random traffic against the arithmetic model
        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 10000) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a        = 16'($urandom);
                bus.b        = 16'($urandom);
                bus.bin      = 1'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_extra", outv(), 32'd0);
                end else begin
                    ex = q.pop_front();
                    chk_res("rand", ex, qa.pop_front(), qb.pop_front(),
                            qbin.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.bin));
                qa.push_back(bus.a);
                qb.push_back(bus.b);
                qbin.push_back(bus.bin);
                sent++;
            end
            step();
            cyc++;
        end
        chk("rand_done", {sent, 32'(q.size())} != {32'd10000, 32'd0} ?
            32'd1 : 32'd0, 32'd0);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule

// File: doc/bk_sub_pipe.md
Name: bk_sub_pipe

Overview:
- Pipelined 16-bit Brent-Kung subtractor: d = a - b - bin, built as a + ~b + ~bin through a Brent-Kung parallel-prefix carry network.
- Companion to the combinational BK adder; it serves the datapath's subtract/compare path.
- Registered between stages, with a valid/ready handshake on both sides so it sits in streaming datapaths with backpressure.

Parameters:
- WIDTH, 16, operand width; must be a power of 2, at least 4.
- LOG2W, 4, log2(WIDTH); sets the number of up-sweep and down-sweep prefix levels.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in (1 = subtract an extra 1).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- d  output  WIDTH  difference, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset values: all stage valid bits 0, so out_valid=0. d, bout and ovf are 0. in_ready=1 in the first cycle after rst deasserts.
- Arithmetic:
  - Internal carry-in c0 = ~bin; operand B' = ~b.
  - Per bit: g_i = a_i & B'_i, p_i = a_i ^ B'_i.
  - Prefix network: Brent-Kung only (up-sweep LOG2W levels, down-sweep LOG2W-1 levels). Kogge-Stone or ripple is not permitted.
  - d_i = p_i ^ c_i.
  - bout = ~c_WIDTH.
  - ovf = c_WIDTH ^ c_(WIDTH-1).
- Pipeline: 3 stages.
  - S1 registers g, p, c0 and a_msb/b_msb.
  - S2 registers the group (G,P) after the up-sweep.
  - S3 registers d, bout and ovf after the down-sweep and sum.
- Latency: exactly 3 cycles from accepted input to out_valid with no stalls. Throughput is 1 beat per cycle.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - Stage k advances when it is empty or the downstream stage advances this cycle.
  - in_ready = ~S1_valid | S1_advance.
  - in_ready may depend combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- Stall hold: while out_valid=1 and out_ready=0, d, bout and ovf hold stable. A full pipe then holds 3 beats with in_ready=0.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts and emits on the same edge; no bubble is inserted.
- Ordering: beats are never dropped or duplicated; results leave in input order.
- Reset mid-operation: rst flushes all in-flight beats. out_valid=0 on the next cycle; no partial result is emitted.
- Wrap-around: results are modulo 2^WIDTH and bout reports the wrap. Example: 0x0000-0x0001 gives d=0xFFFF, bout=1.

Optional Feature:
- Macro: BK_SUB_FLAGS_EN.
- When defined:
  - Adds output port zero (1 bit) = (d == 0), registered in S3 alongside d.
  - Adds output port lt_s (1 bit) = signed a < b + bin, computed as d_msb ^ ovf.
  - Both reset to 0 and follow the same hold rules as d.
- When not defined: neither port exists and no related logic is present.

Test Plan:
- a=0x9999, b=0x1000, bin=1, out_ready=1 -> 3 cycles later d=0x8998, bout=0, ovf=0.
- Streamed back-to-back, out_ready=1:
  - (0x000A, 0x100F, 0) -> d=0xEFFB, bout=1.
  - (0x1212, 0xABCD, 0) -> d=0x6645, bout=1.
  - (0x1235, 0x1004, 1) -> d=0x0230, bout=0.
  - Results appear on 3 consecutive cycles, in order.
- Overflow and boundaries:
  - a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, ovf=1, bout=0.
  - a=0xFFFF, b=0xFFFF, bin=1 -> d=0xFFFF, bout=1, ovf=0.
  - a=b=0x1234, bin=0 -> d=0, bout=0 (zero=1 under BK_SUB_FLAGS_EN).
- Backpressure:
  - Hold out_ready=0 while streaming 5 beats -> in_ready drops to 0 after 3 beats are accepted; d stays stable.
  - Release out_ready -> all beats emerge in order with no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, in_ready=1, neither beat ever appears.
- Random: 10k random (a, b, bin) beats with random out_ready -> every result matches the reference {bout, d} = {1'b0, a} - b - bin (with bout taken as the borrow) and the ovf formula.
